bram_tdp_be_cfg: RTL and testbench
==================================

Name: bram_tdp_be_cfg

Overview:
- Single-clock true-dual-port block RAM with per-byte write enables.
- Per-port write mode (WRITE_FIRST / READ_FIRST / NO_CHANGE), 0-2 output pipeline stages with per-port valid tracking, and deterministic same-address collision resolution with a collision flag.
- Optional hardware clear-on-reset sequencer zeroes the array after reset.
- Used as the shared scratchpad/buffer primitive wherever both ports run in one clock domain.

Parameters:
- NB_COL, 4, number of byte columns per word.
- COL_WIDTH, 8, bits per column (8 or 9).
- RAM_DEPTH, 512, number of words (>=2); ADDR_W = ceil(log2(RAM_DEPTH)).
- OUT_STAGES, 1, output register stages after the array read register (0, 1 or 2).
- WRITE_MODE_A, "READ_FIRST", port A mode: "WRITE_FIRST", "READ_FIRST" or "NO_CHANGE".
- WRITE_MODE_B, "READ_FIRST", port B mode, same encoding.
- COLLISION_PRIORITY, "A", port whose byte wins on a same-address, same-byte double write.
- CLEAR_ON_RESET, 1, 1 = sequential zero-fill after reset; 0 = contents untouched by reset.

Ports:
- clk  in  1  single clock for both ports
- rst  in  1  synchronous active-high reset
- ena / enb  in  1  port enable
- wea / web  in  NB_COL  byte write enables, qualified by ena / enb
- addra / addrb  in  ADDR_W  word address
- dina / dinb  in  NB_COL*COL_WIDTH  write data
- regcea / regceb  in  1  output-stage advance enable
- douta / doutb  out  NB_COL*COL_WIDTH  read data
- vala / valb  out  1  douta / doutb holds data from a completed read
- init_busy  out  1  clear sequencer active; port requests ignored
- collision  out  1  one-cycle pulse, registered, for a same-address conflict in the previous cycle

Behaviour:
- Decided interface: one clock; reset is synchronous and active-high. Ports are clk and rst.
- Reset cycle (rst=1):
  - douta, doutb, all pipeline registers, vala, valb and collision go to 0.
  - The FSM goes to CLEAR if CLEAR_ON_RESET=1, else READY.
  - Clear counter goes to 0. Array contents are not touched in the rst cycle itself.
- FSM, CLEAR state:
  - Each cycle writes all-zero to address cnt, then cnt++.
  - After writing RAM_DEPTH-1, go to READY. The clear takes exactly RAM_DEPTH cycles after rst deasserts.
  - init_busy=1 throughout CLEAR.
  - ena/enb/wea/web are ignored: no writes, no new valids.
  - rst asserted mid-CLEAR restarts at cnt=0.
- FSM, READY state: init_busy=0; normal port operation.
- Stage0 (array read register), per port, updated when en=1 and READY:
  - WRITE_FIRST: written bytes take din; unwritten bytes take mem.
  - READ_FIRST: all bytes take the pre-write mem contents.
  - NO_CHANGE: if any we bit is set, stage0 data holds and v0=0; otherwise it is a normal read.
  - v0 <= en & READY & ~(NO_CHANGE & |we).
  - When en=0, stage0 data holds and v0=0.
- Output stages:
  - OUT_STAGES registers follow stage0. They and their valid bits shift together only when regce=1; when regce=0 they hold.
  - With OUT_STAGES=0, dout/val come straight from stage0 and regce is ignored.
  - Read latency from a request to dout is 1+OUT_STAGES cycles with regce held high.
- Collisions (ena=enb=1, addra==addrb, READY):
  - Byte written by both ports: COLLISION_PRIORITY port data is stored.
  - A port's read of bytes written by the other port in the same cycle returns the old contents; its own WRITE_FIRST bytes return its own din.
  - collision=1 on the next cycle if any we bit on either port is set; pure read/read sets no flag.
- Address compare is on the full ADDR_W. Addresses >= RAM_DEPTH (non-power-of-2 depth) ignore writes, and reads return 0.
- No combinational path from any input to any output.

Test Plan:
- Parameters for all tests: NB_COL=4, COL_WIDTH=8, RAM_DEPTH=16, OUT_STAGES=1, CLEAR_ON_RESET=1, preload 0xFFFFFFFF everywhere.
- Clear: pulse rst → init_busy=1 for exactly 16 cycles. Then reading addr 0..15 gives 0x00000000, with vala first high 2 cycles after each request. A write attempted during CLEAR is absent.
- Byte enable / READ_FIRST: A writes 0x11223344 to addr 3 with wea=4'b1111. Then A writes 0xAABBCCDD with wea=4'b0101 → that request's douta=0x11223344. A following read gives 0x11BB33DD.
- WRITE_FIRST / NO_CHANGE: set B=WRITE_FIRST, A=NO_CHANGE. B writes 0xDEADBEEF, web=4'b1100, over 0x11223344 → doutb=0xDEAD3344. Then A writes with a prior douta=X → douta stays X and vala stays 0.
- Collision: A writes 0x000000AA and B writes 0x000000BB, same addr 5, byte 0 both → mem[5][7:0]=0xAA with priority A (0xBB with priority B). collision=1 for exactly one cycle; read/read at the same address gives collision=0.
- Stall: with OUT_STAGES=2, hold regcea=0 for 3 cycles after a read → douta and vala frozen; resume → data appears and vala=1.
- Reset mid-operation: assert rst at cnt=7 during CLEAR, and separately with a read in flight → outputs 0 the next cycle, clear restarts, and the full 16 cycles elapse before init_busy=0.

Source files
------------

// File: rtl/bram_tdp_be_cfg.sv
// True-dual-port byte-enabled block RAM, single clock, with optional
// zero-fill of the whole array after reset and a registered collision flag.

// Per-port read path: array read register (stage0) plus OUT_STAGES
// regce-gated output registers, each carrying its own valid bit.
module bram_tdp_be_port #(
    parameter int    NB_COL     = 4,
    parameter int    COL_WIDTH  = 8,
    parameter int    OUT_STAGES = 1,
    parameter string WRITE_MODE = "READ_FIRST",
    localparam int   DW         = NB_COL * COL_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [NB_COL-1:0] i_we,
    input  logic [DW-1:0]     i_din,
    input  logic [DW-1:0]     i_old,
    input  logic              i_inrng,
    input  logic              i_regce,
    output logic [DW-1:0]     o_dout,
    output logic              o_val
);
    localparam bit WF = (WRITE_MODE == "WRITE_FIRST");
    localparam bit NC = (WRITE_MODE == "NO_CHANGE");

    logic [DW-1:0] r_d0;
    logic          r_v0;
    logic [DW-1:0] w_s0;
    logic          w_load;

    // NO_CHANGE writes leave the read register untouched and produce no valid
    assign w_load = i_req & ~(NC & (|i_we));

    // Stage0 word: own written bytes in WRITE_FIRST, otherwise pre-write contents
    always_comb begin
        w_s0 = '0;
        if (i_inrng) begin
            for (int c = 0; c < NB_COL; c++) begin
                w_s0[c*COL_WIDTH +: COL_WIDTH] = (WF && i_we[c]) ?
                    i_din[c*COL_WIDTH +: COL_WIDTH] : i_old[c*COL_WIDTH +: COL_WIDTH];
            end
        end
    end

    // Array read register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_d0 <= '0;
            r_v0 <= 1'b0;
        end else begin
            r_v0 <= w_load;
            if (w_load) r_d0 <= w_s0;
        end
    end

    if (OUT_STAGES == 0) begin : g_no_out
        logic w_unused_regce;
        assign w_unused_regce = i_regce;
        assign o_dout = r_d0;
        assign o_val  = r_v0;
    end else begin : g_out
        logic [DW-1:0]         r_pd [OUT_STAGES];
        logic [OUT_STAGES-1:0] r_pv;

        // Output shift chain, frozen while regce is low
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < OUT_STAGES; i++) r_pd[i] <= '0;
                r_pv <= '0;
            end else if (i_regce) begin
                r_pd[0] <= r_d0;
                r_pv[0] <= r_v0;
                for (int i = 1; i < OUT_STAGES; i++) begin
                    r_pd[i] <= r_pd[i-1];
                    r_pv[i] <= r_pv[i-1];
                end
            end
        end

        assign o_dout = r_pd[OUT_STAGES-1];
        assign o_val  = r_pv[OUT_STAGES-1];
    end
endmodule

module bram_tdp_be_cfg #(
    parameter int    NB_COL             = 4,
    parameter int    COL_WIDTH          = 8,
    parameter int    RAM_DEPTH          = 512,
    parameter int    OUT_STAGES         = 1,
    parameter string WRITE_MODE_A       = "READ_FIRST",
    parameter string WRITE_MODE_B       = "READ_FIRST",
    parameter string COLLISION_PRIORITY = "A",
    parameter int    CLEAR_ON_RESET     = 1,
    localparam int   ADDR_W             = $clog2(RAM_DEPTH),
    localparam int   DW                 = NB_COL * COL_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              enb,
    input  logic [NB_COL-1:0] wea,
    input  logic [NB_COL-1:0] web,
    input  logic [ADDR_W-1:0] addra,
    input  logic [ADDR_W-1:0] addrb,
    input  logic [DW-1:0]     dina,
    input  logic [DW-1:0]     dinb,
    input  logic              regcea,
    input  logic              regceb,
    output logic [DW-1:0]     douta,
    output logic [DW-1:0]     doutb,
    output logic              vala,
    output logic              valb,
    output logic              init_busy,
    output logic              collision
);
    localparam bit                PRIO_A = (COLLISION_PRIORITY == "A");
    localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(RAM_DEPTH - 1);

    typedef enum logic {S_CLEAR, S_READY} state_t;

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_cnt, w_cnt_nxt;
    logic              w_busy;
    logic              r_coll;
    logic [DW-1:0]     r_mem [RAM_DEPTH];

    logic              w_ready, w_clr, w_same, w_ina, w_inb, w_req_a, w_req_b;
    logic [NB_COL-1:0] w_we_a, w_we_b, w_both, w_wr_a, w_wr_b;
    logic [DW-1:0]     w_rd_a, w_rd_b;

    if (2**ADDR_W == RAM_DEPTH) begin : g_full
        assign w_ina = 1'b1;
        assign w_inb = 1'b1;
    end else begin : g_part
        assign w_ina = int'(addra) < RAM_DEPTH;
        assign w_inb = int'(addrb) < RAM_DEPTH;
    end

    assign w_ready = (r_state == S_READY) & ~rst;
    assign w_clr   = (r_state == S_CLEAR) & ~rst;
    assign w_req_a = ena & w_ready;
    assign w_req_b = enb & w_ready;
    assign w_same  = (addra == addrb);
    assign w_we_a  = (w_req_a & w_ina) ? wea : '0;
    assign w_we_b  = (w_req_b & w_inb) ? web : '0;
    // Bytes hit by both ports at one address go only to the priority port
    assign w_both  = w_we_a & w_we_b & {NB_COL{w_same}};
    assign w_wr_a  = PRIO_A ? w_we_a : (w_we_a & ~w_both);
    assign w_wr_b  = PRIO_A ? (w_we_b & ~w_both) : w_we_b;
    assign w_rd_a  = w_ina ? r_mem[addra] : '0;
    assign w_rd_b  = w_inb ? r_mem[addrb] : '0;

    // Clear/ready state register and clear address counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Walk every address once, then hand the array to the ports
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_busy      = 1'b0;
        case (r_state)
            S_CLEAR: begin
                w_busy    = 1'b1;
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == LAST) begin
                    w_state_nxt = S_READY;
                    w_cnt_nxt   = '0;
                end
            end
            default: ;
        endcase
    end

    // Array writes: clear fill or per-byte port writes
    always_ff @(posedge clk) begin
        if (w_clr) r_mem[r_cnt] <= '0;
        for (int c = 0; c < NB_COL; c++) begin
            if (w_wr_a[c]) r_mem[addra][c*COL_WIDTH +: COL_WIDTH] <= dina[c*COL_WIDTH +: COL_WIDTH];
            if (w_wr_b[c]) r_mem[addrb][c*COL_WIDTH +: COL_WIDTH] <= dinb[c*COL_WIDTH +: COL_WIDTH];
        end
    end

    // Same-address access with any write flags a collision one cycle later
    always_ff @(posedge clk) begin
        if (rst) r_coll <= 1'b0;
        else     r_coll <= ena & enb & w_ready & w_same & ((|wea) | (|web));
    end

    bram_tdp_be_port #(
        .NB_COL(NB_COL), .COL_WIDTH(COL_WIDTH), .OUT_STAGES(OUT_STAGES),
        .WRITE_MODE(WRITE_MODE_A)
    ) u_port_a (
        .clk(clk), .rst(rst), .i_req(w_req_a), .i_we(wea), .i_din(dina),
        .i_old(w_rd_a), .i_inrng(w_ina), .i_regce(regcea),
        .o_dout(douta), .o_val(vala)
    );

    bram_tdp_be_port #(
        .NB_COL(NB_COL), .COL_WIDTH(COL_WIDTH), .OUT_STAGES(OUT_STAGES),
        .WRITE_MODE(WRITE_MODE_B)
    ) u_port_b (
        .clk(clk), .rst(rst), .i_req(w_req_b), .i_we(web), .i_din(dinb),
        .i_old(w_rd_b), .i_inrng(w_inb), .i_regce(regceb),
        .o_dout(doutb), .o_val(valb)
    );

    assign init_busy = w_busy;
    assign collision = r_coll;
endmodule

// File: tb/tb_bram_tdp_be_cfg.sv
// Two instances share one stimulus stream:
//   u0: 1 output stage, A READ_FIRST, B WRITE_FIRST, port A wins collisions
//   u1: 2 output stages, A NO_CHANGE, B READ_FIRST, port B wins collisions
module tb_bram_tdp_be_cfg;
    logic        clk = 1'b0;
    logic        rst, ena, enb, regcea, regceb;
    logic [3:0]  wea, web, addra, addrb;
    logic [31:0] dina, dinb;
    logic [31:0] douta0, doutb0, douta1, doutb1;
    logic        vala0, valb0, busy0, col0, vala1, valb1, busy1, col1;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    bram_tdp_be_cfg #(
        .NB_COL(4), .COL_WIDTH(8), .RAM_DEPTH(16), .OUT_STAGES(1),
        .WRITE_MODE_A("READ_FIRST"), .WRITE_MODE_B("WRITE_FIRST"),
        .COLLISION_PRIORITY("A"), .CLEAR_ON_RESET(1)
    ) u0 (
        .clk(clk), .rst(rst), .ena(ena), .enb(enb), .wea(wea), .web(web),
        .addra(addra), .addrb(addrb), .dina(dina), .dinb(dinb),
        .regcea(regcea), .regceb(regceb), .douta(douta0), .doutb(doutb0),
        .vala(vala0), .valb(valb0), .init_busy(busy0), .collision(col0)
    );

    bram_tdp_be_cfg #(
        .NB_COL(4), .COL_WIDTH(8), .RAM_DEPTH(16), .OUT_STAGES(2),
        .WRITE_MODE_A("NO_CHANGE"), .WRITE_MODE_B("READ_FIRST"),
        .COLLISION_PRIORITY("B"), .CLEAR_ON_RESET(1)
    ) u1 (
        .clk(clk), .rst(rst), .ena(ena), .enb(enb), .wea(wea), .web(web),
        .addra(addra), .addrb(addrb), .dina(dina), .dinb(dinb),
        .regcea(regcea), .regceb(regceb), .douta(douta1), .doutb(doutb1),
        .vala(vala1), .valb(valb1), .init_busy(busy1), .collision(col1)
    );

    // ---------------- reference model ----------------
    // Memory image, remaining clear cycles, and a history of read-register
    // results (index 0 = newest); the output shows the entry OUT_STAGES old.
    logic [31:0] mm   [2][16];
    logic [31:0] ha_d [2][4];
    logic [31:0] hb_d [2][4];
    logic        ha_v [2][4];
    logic        hb_v [2][4];
    logic        ecol [2];
    int          clr_left [2];

    function automatic int os_of(input int k);   return (k == 0) ? 1 : 2; endfunction
    // mode: 0 READ_FIRST, 1 WRITE_FIRST, 2 NO_CHANGE
    function automatic int mode_a(input int k);  return (k == 0) ? 0 : 2; endfunction
    function automatic int mode_b(input int k);  return (k == 0) ? 1 : 0; endfunction
    function automatic bit prio_a(input int k);  return (k == 0); endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int c = 0; c < 4; c++) if (m[c]) r[c*8 +: 8] = nw[c*8 +: 8];
        return r;
    endfunction

    task automatic model_step(input int k);
        logic [3:0]  am, bm;
        logic [31:0] olda, oldb;
        if (rst) begin
            clr_left[k] = 16;
            ecol[k] = 1'b0;
            for (int i = 0; i < 4; i++) begin
                ha_d[k][i] = '0; ha_v[k][i] = 1'b0;
                hb_d[k][i] = '0; hb_v[k][i] = 1'b0;
            end
            return;
        end
        ecol[k] = 1'b0;
        for (int i = 3; i > 0; i--) begin
            ha_d[k][i] = ha_d[k][i-1]; ha_v[k][i] = ha_v[k][i-1];
            hb_d[k][i] = hb_d[k][i-1]; hb_v[k][i] = hb_v[k][i-1];
        end
        ha_v[k][0] = 1'b0;
        hb_v[k][0] = 1'b0;
        if (clr_left[k] > 0) begin
            clr_left[k]--;
            if (clr_left[k] == 0) for (int i = 0; i < 16; i++) mm[k][i] = '0;
            return;
        end
        olda = mm[k][addra];
        oldb = mm[k][addrb];
        if (ena && !(mode_a(k) == 2 && wea != 0)) begin
            ha_d[k][0] = merge(olda, dina, (mode_a(k) == 1) ? wea : 4'h0);
            ha_v[k][0] = 1'b1;
        end
        if (enb && !(mode_b(k) == 2 && web != 0)) begin
            hb_d[k][0] = merge(oldb, dinb, (mode_b(k) == 1) ? web : 4'h0);
            hb_v[k][0] = 1'b1;
        end
        ecol[k] = ena && enb && (addra == addrb) && (wea != 0 || web != 0);
        am = ena ? wea : 4'h0;
        bm = enb ? web : 4'h0;
        if (addra == addrb) begin
            if (prio_a(k)) bm = bm & ~am;
            else           am = am & ~bm;
        end
        mm[k][addra] = merge(mm[k][addra], dina, am);
        mm[k][addrb] = merge(mm[k][addrb], dinb, bm);
    endtask

    initial forever begin
        @(posedge clk);
        model_step(0);
        model_step(1);
    end

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic cmp(input int k);
        logic [31:0] da, db;
        logic        va, vb, bz, cl;
        da = (k == 0) ? douta0 : douta1;  db = (k == 0) ? doutb0 : doutb1;
        va = (k == 0) ? vala0  : vala1;   vb = (k == 0) ? valb0  : valb1;
        bz = (k == 0) ? busy0  : busy1;   cl = (k == 0) ? col0   : col1;
        chk($sformatf("u%0d.douta", k), da, ha_d[k][os_of(k)]);
        chk($sformatf("u%0d.vala", k), 32'(va), 32'(ha_v[k][os_of(k)]));
        chk($sformatf("u%0d.doutb", k), db, hb_d[k][os_of(k)]);
        chk($sformatf("u%0d.valb", k), 32'(vb), 32'(hb_v[k][os_of(k)]));
        chk($sformatf("u%0d.init_busy", k), 32'(bz), 32'(clr_left[k] > 0));
        chk($sformatf("u%0d.collision", k), 32'(cl), 32'(ecol[k]));
    endtask

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            cmp(0);
            cmp(1);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        ena = 1'b0; enb = 1'b0; wea = '0; web = '0;
    endtask
    task automatic pa(input logic [3:0] we, input logic [3:0] ad, input logic [31:0] d);
        ena = 1'b1; wea = we; addra = ad; dina = d;
    endtask
    task automatic pb(input logic [3:0] we, input logic [3:0] ad, input logic [31:0] d);
        enb = 1'b1; web = we; addrb = ad; dinb = d;
    endtask
    task automatic nx();
        @(negedge clk);
    endtask

    // Counts cycles with init_busy high, optionally attempting a write mid-clear
    task automatic wait_clear(input string nm, input bit wr_during);
        int n;
        n = 0;
        while (busy0 === 1'b1 && n < 40) begin
            if (wr_during && n == 10) pa(4'hF, 4'd0, 32'h12345678);
            else idle();
            n++;
            nx();
        end
        idle();
        chk(nm, 32'(n), 32'd16);
    endtask

    initial begin
        rst = 1'b1; idle();
        addra = '0; addrb = '0; dina = '0; dinb = '0;
        regcea = 1'b1; regceb = 1'b1;
        repeat (2) nx();
        chk("rst.douta0", douta0, 32'h0);   chk("rst.vala0", 32'(vala0), 32'd0);
        chk("rst.doutb1", doutb1, 32'h0);   chk("rst.valb1", 32'(valb1), 32'd0);
        chk("rst.col0", 32'(col0), 32'd0);  chk("rst.busy1", 32'(busy1), 32'd1);
        chk_en = 1'b1;
        rst = 1'b0;
        wait_clear("clr_first", 1'b0);

        // fill every word with ones, then clear again
        for (int i = 0; i < 8; i++) begin
            pa(4'hF, 4'(2*i), 32'hFFFF_FFFF);
            pb(4'hF, 4'(2*i+1), 32'hFFFF_FFFF);
            nx();
        end
        idle(); nx();
        rst = 1'b1; nx();
        rst = 1'b0;
        wait_clear("clr_len", 1'b1);

        // read sweep: everything zero, valid two cycles after each request
        for (int i = 0; i < 18; i++) begin
            if (i < 16) pa(4'h0, 4'(i), 32'h0);
            else idle();
            nx();
            if (i == 0) chk("sweep.lat", 32'(vala0), 32'd0);
            if (i >= 1 && i <= 16) begin
                chk("sweep.douta0", douta0, 32'h0);
                chk("sweep.vala0", 32'(vala0), 32'd1);
            end
            if (i >= 2) chk("sweep.vala1", 32'(vala1), 32'd1);
        end
        idle(); nx();

        // byte enables and READ_FIRST / NO_CHANGE on port A
        pa(4'hF, 4'd3, 32'h1122_3344); nx();
        pa(4'h5, 4'd3, 32'hAABB_CCDD); nx();
        pa(4'h0, 4'd3, 32'h0);         nx();
        chk("rf.douta0", douta0, 32'h1122_3344);
        chk("rf.vala0", 32'(vala0), 32'd1);
        chk("nc.vala1_wr", 32'(vala1), 32'd0);
        idle(); nx();
        chk("be.douta0", douta0, 32'h11BB_33DD);
        pa(4'hF, 4'd3, 32'h5555_5555); nx();
        chk("be.douta1", douta1, 32'h11BB_33DD);
        chk("be.vala1", 32'(vala1), 32'd1);
        idle(); nx(); nx();
        chk("nc.hold_douta1", douta1, 32'h11BB_33DD);
        chk("nc.hold_vala1", 32'(vala1), 32'd0);

        // WRITE_FIRST on port B (u0), READ_FIRST on port B (u1)
        pa(4'hF, 4'd4, 32'h1122_3344); nx();
        idle(); pb(4'hC, 4'd4, 32'hDEAD_BEEF); nx();
        idle(); nx();
        chk("wf.doutb0", doutb0, 32'hDEAD_3344);
        chk("wf.valb0", 32'(valb0), 32'd1);
        nx();
        chk("rfb.doutb1", doutb1, 32'h1122_3344);

        // same-address double write, then read/read
        pa(4'h1, 4'd5, 32'h0000_00AA); pb(4'h1, 4'd5, 32'h0000_00BB); nx();
        chk("col.pulse0", 32'(col0), 32'd1);
        chk("col.pulse1", 32'(col1), 32'd1);
        pa(4'h0, 4'd5, 32'h0); pb(4'h0, 4'd5, 32'h0); nx();
        chk("col.end0", 32'(col0), 32'd0);
        idle(); nx();
        chk("col.rdrd0", 32'(col0), 32'd0);
        chk("col.prioA", douta0, 32'h0000_00AA);
        chk("col.prioA_b", doutb0, 32'h0000_00AA);
        nx();
        chk("col.prioB", douta1, 32'h0000_00BB);
        chk("col.prioB_b", doutb1, 32'h0000_00BB);
        nx(); nx();

        // output stall on port A of u1
        chk_en = 1'b0;
        pa(4'h0, 4'd4, 32'h0); nx();
        idle(); nx();
        regcea = 1'b0;
        for (int i = 0; i < 3; i++) begin
            nx();
            chk("stall.douta1", douta1, 32'h0000_00BB);
            chk("stall.vala1", 32'(vala1), 32'd0);
        end
        regcea = 1'b1; nx();
        chk("resume.douta1", douta1, 32'hDEAD_3344);
        chk("resume.vala1", 32'(vala1), 32'd1);

        // reset with a read in flight
        pa(4'h0, 4'd4, 32'h0); nx();
        rst = 1'b1; idle();
        @(posedge clk); #1;
        chk_en = 1'b1;
        nx();
        chk("rstfl.douta0", douta0, 32'h0);  chk("rstfl.vala0", 32'(vala0), 32'd0);
        chk("rstfl.douta1", douta1, 32'h0);  chk("rstfl.vala1", 32'(vala1), 32'd0);
        rst = 1'b0;

        // reset again at clear count 7
        repeat (7) nx();
        chk("mid.busy0", 32'(busy0), 32'd1);
        rst = 1'b1; nx();
        rst = 1'b0;
        wait_clear("clr_restart", 1'b0);

        pa(4'h0, 4'd3, 32'h0); nx();
        idle(); nx();
        chk("final.douta0", douta0, 32'h0);
        chk("final.vala0", 32'(vala0), 32'd1);
        repeat (4) nx();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
